// File: rtl/data_memory_master.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_master
// Description : Serialises CPU byte/word load-store requests onto a byte-wide
//               data memory port. Word accesses are split into four
//               little-endian byte beats; loads alternate an issue cycle with
//               a capture cycle because the memory returns data one cycle
//               after the read strobe. Misaligned word accesses are rejected
//               without touching memory.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset_n           clock, synchronous active-low reset
//   req_valid/req_ready    request handshake (ready only while idle)
//   req_write, req_word    1 = store / 1 = 32-bit word access
//   req_addr, req_wdata    byte address and store data
//   rsp_valid              one-cycle completion pulse
//   rsp_rdata, rsp_error   load result / misaligned flag, held between pulses
//   mem_address            byte address to memory (held outside ISSUE)
//   mem_write_enable       01 = byte write, otherwise 00
//   mem_read_enable        01 = byte read, otherwise 00
//   mem_write_data         byte to be written (held outside ISSUE)
//   mem_read_data          registered read byte from memory
// ============================================================================
module data_memory_master #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_word,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic [1:0]        mem_write_enable,
    output logic [1:0]        mem_read_enable,
    output logic [7:0]        mem_write_data,
    input  logic [7:0]        mem_read_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t            state;
    logic [1:0]        byte_idx;     // current beat k within the access
    logic [ADDR_W-1:0] base_addr;
    logic              is_write;
    logic              is_word;
    logic [31:0]       wdata;
    logic [31:0]       result;       // load bytes gathered so far
    logic              write_strobe;
    logic              read_strobe;

    // Derived per-beat values
    logic [1:0]        next_idx;
    logic [ADDR_W-1:0] next_addr;
    logic              last_beat;
    logic [7:0]        next_wbyte;
    logic [31:0]       merged;
    logic              misaligned;

    always_comb begin
        next_idx   = byte_idx + 2'd1;
        // Only the low two bits ever advance; addition wraps naturally at 2^ADDR_W.
        next_addr  = base_addr + {{(ADDR_W-2){1'b0}}, next_idx};
        last_beat  = is_word ? (byte_idx == 2'd3) : 1'b1;
        next_wbyte = wdata[{next_idx, 3'b000} +: 8];
        // Load result with the byte returned by memory dropped into slot k.
        merged     = result;
        merged[{byte_idx, 3'b000} +: 8] = mem_read_data;
        misaligned = req_word && (req_addr[1:0] != 2'b00);
    end

    // Ready and strobes are additionally qualified by reset_n so that
    // asserting reset mid-access suppresses a strobe already registered for
    // the current cycle: the memory never sees a beat after reset asserts.
    assign req_ready        = reset_n && (state == IDLE);
    assign mem_write_enable = {1'b0, write_strobe & reset_n};
    assign mem_read_enable  = {1'b0, read_strobe  & reset_n};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            byte_idx       <= 2'd0;
            base_addr      <= '0;
            is_write       <= 1'b0;
            is_word        <= 1'b0;
            wdata          <= 32'd0;
            result         <= 32'd0;
            write_strobe   <= 1'b0;
            read_strobe    <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= 32'd0;
            rsp_error      <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= 8'd0;
        end else begin
            // Strobes and the response pulse last a single cycle unless
            // re-armed below by the transition that needs them.
            write_strobe <= 1'b0;
            read_strobe  <= 1'b0;
            rsp_valid    <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        base_addr <= req_addr;
                        is_write  <= req_write;
                        is_word   <= req_word;
                        wdata     <= req_wdata;
                        byte_idx  <= 2'd0;
                        result    <= 32'd0;
                        if (misaligned) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b1;
                            rsp_rdata <= 32'd0;
                        end else begin
                            // First beat is presented in the ISSUE cycle.
                            state       <= ISSUE;
                            mem_address <= req_addr;
                            if (req_write) begin
                                write_strobe   <= 1'b1;
                                mem_write_data <= req_wdata[7:0];
                            end else begin
                                read_strobe <= 1'b1;
                            end
                        end
                    end
                end

                ISSUE: begin
                    if (is_write) begin
                        if (last_beat) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_error <= 1'b0;
                            rsp_rdata <= 32'd0;
                        end else begin
                            byte_idx       <= next_idx;
                            mem_address    <= next_addr;
                            mem_write_data <= next_wbyte;
                            write_strobe   <= 1'b1;
                        end
                    end else begin
                        // Memory samples the read strobe at this edge and
                        // presents the byte during CAPTURE.
                        state <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    result <= merged;
                    if (last_beat) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_error <= 1'b0;
                        rsp_rdata <= merged;
                    end else begin
                        state       <= ISSUE;
                        byte_idx    <= next_idx;
                        mem_address <= next_addr;
                        read_strobe <= 1'b1;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory_master
// Description : Self-checking bench for data_memory_master. A byte memory
//               model answers the DUT port; a reference byte array predicts
//               load results, beat sequences and latencies per transaction.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_word;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [11:0] mem_address;
    logic [1:0]  mem_write_enable;
    logic [1:0]  mem_read_enable;
    logic [7:0]  mem_write_data;
    logic [7:0]  mem_read_data;

    int tests = 0;
    int fails = 0;

    logic [7:0] ref_mem [4096];

    data_memory_master #(.ADDR_W(12)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_word         (req_word),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_error        (rsp_error),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    // Initial memory contents as a pure function of address.
    function automatic logic [7:0] init_byte(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], 4'h5} ^ 8'hA5;
    endfunction

    // Byte memory model with registered read data.
    logic [7:0] tb_mem  [4096];
    bit         written [4096];
    always @(posedge clk) begin
        if (mem_write_enable == 2'b01) begin
            tb_mem[mem_address]  <= mem_write_data;
            written[mem_address] <= 1'b1;
        end
        if (mem_read_enable == 2'b01)
            mem_read_data <= written[mem_address] ? tb_mem[mem_address] : init_byte(mem_address);
    end

    function automatic logic [7:0] mem_peek(input logic [11:0] a);
        return written[a] ? tb_mem[a] : init_byte(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        @(negedge clk);
        for (int t = 0; t < 20 && req_ready !== 1'b1; t++) @(negedge clk);
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
    endtask

    // One complete transaction: predicts beats, latency and result from the
    // reference memory, then checks the DUT cycle by cycle.
    task automatic do_req(input bit wr, input bit wd, input logic [11:0] a, input logic [31:0] d);
        bit          mis;
        int          n, lat_exp, lat, seen;
        logic [31:0] rd_exp;
        logic [31:0] rd_seen;
        logic [11:0] ea;
        mis     = wd && (a[1:0] != 2'b00);
        n       = mis ? 0 : (wd ? 4 : 1);
        lat_exp = mis ? 1 : (wr ? n + 1 : 2 * n + 1);
        rd_exp  = 32'd0;
        if (!mis && !wr)
            for (int i = 0; i < n; i++) rd_exp[8*i +: 8] = ref_mem[a + 12'(i)];

        wait_ready();
        req_valid = 1'b1; req_write = wr; req_word = wd; req_addr = a; req_wdata = d;
        @(posedge clk);
        #1;
        // Scramble request fields: they must be ignored outside acceptance.
        req_valid = 1'b0;
        req_write = 1'($urandom); req_word = 1'($urandom);
        req_addr = 12'($urandom); req_wdata = $urandom;

        lat = -1; seen = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_write_enable != 2'b00 || mem_read_enable != 2'b00) begin
                ea = a + 12'(seen);
                check("beat_we",   {30'd0, mem_write_enable}, wr ? 32'd1 : 32'd0);
                check("beat_re",   {30'd0, mem_read_enable},  wr ? 32'd0 : 32'd1);
                check("beat_addr", {20'd0, mem_address}, {20'd0, ea});
                if (wr) check("beat_wdata", {24'd0, mem_write_data}, {24'd0, 8'(d >> (8*seen))});
                seen++;
            end
            if (rsp_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
        check("latency",   lat,  lat_exp);
        check("beats",     seen, n);
        check("rsp_rdata", rsp_rdata, rd_exp);
        check("rsp_error", {31'd0, rsp_error}, {31'd0, mis});
        rd_seen = rsp_rdata;

        // Pulse is one cycle; response and memory-side outputs hold.
        @(negedge clk);
        check("rsp_pulse_end", {31'd0, rsp_valid}, 32'd0);
        check("rdata_hold", rsp_rdata, rd_exp);
        check("error_hold", {31'd0, rsp_error}, {31'd0, mis});
        check("idle_strobes", {28'd0, mem_write_enable, mem_read_enable}, 32'd0);
        if (n > 0) check("addr_hold", {20'd0, mem_address}, {20'd0, a + 12'(n - 1)});
        if (rd_seen !== rd_exp) fails = fails; // keep rd_seen meaningful only via rdata checks

        if (!mis && wr)
            for (int i = 0; i < n; i++) ref_mem[a + 12'(i)] = d[8*i +: 8];
    endtask

    initial begin
        int pulses, strobes, last;
        bit wr, wd;
        logic [11:0] a;
        logic [31:0] d;

        for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(12'(i));
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_word = 1'b0;
        req_addr = 12'd0; req_wdata = 32'd0;

        // Reset: two cycles low, then release.
        @(negedge clk);
        check("ready_in_reset", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready",  {31'd0, req_ready}, 32'd1);
        check("rst_valid",  {31'd0, rsp_valid}, 32'd0);
        check("rst_strobe", {28'd0, mem_write_enable, mem_read_enable}, 32'd0);
        check("rst_addr",   {20'd0, mem_address}, 32'd0);
        check("rst_wdata",  {24'd0, mem_write_data}, 32'd0);
        check("rst_rdata",  rsp_rdata, 32'd0);
        check("rst_error",  {31'd0, rsp_error}, 32'd0);

        // Directed accesses.
        do_req(1'b1, 1'b0, 12'h010, 32'h123456AA);
        do_req(1'b1, 1'b1, 12'h020, 32'hDDCCBBAA);
        do_req(1'b0, 1'b1, 12'h020, 32'h0);
        check("word_load_value", {ref_mem[12'h023], ref_mem[12'h022], ref_mem[12'h021], ref_mem[12'h020]}, 32'hDDCCBBAA);
        do_req(1'b0, 1'b0, 12'h022, 32'h0);
        do_req(1'b0, 1'b1, 12'h021, 32'h0);
        do_req(1'b1, 1'b1, 12'h013, 32'hCAFEF00D);
        do_req(1'b0, 1'b0, 12'hFFF, 32'h0);

        // Back-to-back: req_valid held high, byte stores to one address.
        wait_ready();
        d = $urandom;
        req_valid = 1'b1; req_write = 1'b1; req_word = 1'b0; req_addr = 12'h080; req_wdata = d;
        pulses = 0; strobes = 0; last = -1;
        for (int c = 0; c < 40 && pulses < 4; c++) begin
            @(negedge clk);
            if (mem_write_enable == 2'b01) strobes++;
            if (rsp_valid === 1'b1) begin
                if (last >= 0) check("b2b_gap", c - last, 3);
                last = c;
                pulses++;
            end
        end
        req_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (mem_write_enable == 2'b01) strobes++;
            if (rsp_valid === 1'b1) pulses++;
        end
        check("b2b_pulses", pulses, 4);
        check("b2b_strobes", strobes, 4);
        ref_mem[12'h080] = d[7:0];
        check("b2b_mem", {24'd0, mem_peek(12'h080)}, {24'd0, ref_mem[12'h080]});

        // Reset in the middle of a word store after its second byte.
        wait_ready();
        req_valid = 1'b1; req_write = 1'b1; req_word = 1'b1; req_addr = 12'h040; req_wdata = 32'h44332211;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("abort_strobe", {28'd0, mem_write_enable, mem_read_enable}, 32'd0);
            check("abort_valid",  {31'd0, rsp_valid}, 32'd0);
            check("abort_ready",  {31'd0, req_ready}, 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_ready_after", {31'd0, req_ready}, 32'd1);
        check("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        ref_mem[12'h040] = 8'h11;
        ref_mem[12'h041] = 8'h22;
        for (int i = 0; i < 4; i++)
            check("abort_mem", {24'd0, mem_peek(12'h040 + 12'(i))}, {24'd0, ref_mem[12'h040 + 12'(i)]});

        // Randomised traffic against the reference memory.
        for (int t = 0; t < 60; t++) begin
            wr = 1'($urandom);
            wd = 1'($urandom);
            a  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 63));
            if (wd && $urandom_range(0, 5) != 0) a[1:0] = 2'b00;
            d  = $urandom;
            do_req(wr, wd, a, d);
        end
        for (int i = 0; i < 64; i++)
            check("final_mem", {24'd0, mem_peek(12'(i))}, {24'd0, ref_mem[i]});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
